// File: rtl/demux_stream_sched.sv
// 1-to-NCH stream demux scheduler: directed or round-robin channel choice, bursts locked to one channel.
// Latency 1 cycle accept->out_valid; backpressure: in_ready follows out_ready of the held channel.
module demux_stream_sched #(
    parameter int DW    = 8,
    parameter int NCH   = 4,
    parameter int SW    = 2,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SW-1:0]     in_dest,
    input  logic              in_last,
    input  logic              mode,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [SW-1:0]     cur_sel,
    output logic              busy,
    output logic              drop
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q;
    logic [NCH-1:0]      out_valid_q;
    logic [NCH*DW-1:0]   out_data_q;
    logic [SW-1:0]       cur_sel_q;
    logic [SW-1:0]       rr_ptr_q;
    logic [7:0]          beat_cnt_q;
    logic                locked_q;
    logic                rr_burst_q;
    logic                drop_q;

    logic                sel_ready;
    logic                accept;
    logic                transfer;
    logic                dest_bad;
    logic                load;
    logic                burst_end;
    logic                burst_rr_d;
    logic [SW-1:0]       sel_d;
    logic [SW-1:0]       rr_next_d;
    logic [7:0]          beat_d;
    logic [NCH*DW-1:0]   lanes_d;
    logic [NCH-1:0]      onehot_d;

    assign sel_ready = out_ready[cur_sel_q];
    assign in_ready  = rst_n & ((state_q == IDLE) | sel_ready);
    assign accept    = in_valid & in_ready;
    assign transfer  = (state_q == SEND) & sel_ready;

    // A locked burst ignores in_dest/mode; only the first word chooses the channel.
    always_comb begin
        sel_d      = cur_sel_q;
        burst_rr_d = rr_burst_q;
        beat_d     = beat_cnt_q + 8'd1;
        dest_bad   = 1'b0;
        if (!locked_q) begin
            burst_rr_d = mode;
            beat_d     = 8'd1;
            sel_d      = mode ? rr_ptr_q : in_dest;
            dest_bad   = !mode && ({1'b0, in_dest} >= (SW+1)'(NCH));
        end
        load      = accept & !dest_bad;
        burst_end = in_last | (beat_d == 8'(BURST));
        rr_next_d = (sel_d == SW'(NCH-1)) ? '0 : sel_d + 1'b1;
    end

    always_comb begin
        lanes_d  = '0;
        onehot_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_d == SW'(k)) begin
                lanes_d[k*DW +: DW] = in_data;
                onehot_d[k]         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= '0;
            out_data_q  <= '0;
            cur_sel_q   <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            locked_q    <= 1'b0;
            rr_burst_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= accept & dest_bad;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (!load && transfer) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load) begin
                cur_sel_q   <= sel_d;
                out_data_q  <= lanes_d;
                out_valid_q <= onehot_d;
                // Lock and beat count survive idle gaps until the burst end word.
                if (burst_end) begin
                    locked_q   <= 1'b0;
                    beat_cnt_q <= '0;
                    if (burst_rr_d) begin
                        rr_ptr_q <= rr_next_d;
                    end
                end else begin
                    locked_q   <= 1'b1;
                    beat_cnt_q <= beat_d;
                    rr_burst_q <= burst_rr_d;
                end
            end else if (transfer) begin
                out_valid_q <= '0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cur_sel   = cur_sel_q;
    assign busy      = locked_q | (state_q == SEND);
    assign drop      = drop_q;

endmodule

// File: tb/tb_demux_stream_sched.sv
module tb_demux_stream_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_dest;
    logic        in_last;
    logic        mode;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  cur_sel;
    logic        busy;
    logic        drop;

    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [1:0]  b_in_dest;
    logic        b_in_last;
    logic        b_mode;
    logic [23:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [1:0]  b_cur_sel;
    logic        b_busy;
    logic        b_drop;

    always #5 clk = ~clk;

    demux_stream_sched #(.DW(8), .NCH(4), .SW(2), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_last(in_last), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cur_sel(cur_sel), .busy(busy), .drop(drop)
    );

    demux_stream_sched #(.DW(8), .NCH(3), .SW(2), .BURST(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_dest(b_in_dest), .in_last(b_in_last), .mode(b_mode), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .cur_sel(b_cur_sel), .busy(b_busy), .drop(b_drop)
    );

    typedef struct {
        int         ch;
        logic [7:0] dat;
    } exp_t;

    typedef struct {
        logic       m;
        logic [1:0] d;
        logic       l;
        logic [7:0] dat;
        int         ch;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one word, wait (bounded) for in_ready, record expectation, return after the accepting edge.
    task automatic send(input logic m, input logic [1:0] d, input logic l, input logic [7:0] dat,
                        input int ch, output int stalls);
        exp_t e;
        stalls = 0;
        mode = m; in_dest = d; in_last = l; in_data = dat; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept data=%0h", dat);
        end else begin
            e.ch = ch;
            e.dat = dat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        exp_t        e;
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            chk("onehot", 64'($countones(out_valid) <= 1), 64'd1);
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=ch%0d:%0h required=none", k, out_data);
                    end else begin
                        e = sb.pop_front();
                        ev = '0;
                        ev[e.ch*8 +: 8] = e.dat;
                        chk("out_ch", 64'(k), 64'(e.ch));
                        chk("out_data", 64'(out_data), 64'(ev));
                    end
                end
            end
        end
    endtask

    initial begin
        int st;
        int total_stalls;
        int n;

        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{1'b1, 2'd0, 1'b0, 8'(8'h10 + i), i / 4};
        end
        tbl[12] = '{1'b0, 2'd3, 1'b0, 8'hA0, 3};
        tbl[13] = '{1'b0, 2'd3, 1'b1, 8'hA1, 3};
        tbl[14] = '{1'b0, 2'd1, 1'b1, 8'hB0, 1};
        tbl[15] = '{1'b1, 2'd0, 1'b1, 8'hC0, 3};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; in_last = 1'b0; mode = 1'b0;
        out_ready = 4'hF;
        b_in_valid = 1'b0; b_in_data = '0; b_in_dest = '0; b_in_last = 1'b0; b_mode = 1'b0;
        b_out_ready = 3'b111;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_cur_sel", 64'(cur_sel), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        fork monitor(); join_none

        // Table: round-robin bursts, directed bursts with in_last, rr pointer untouched by directed
        total_stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].m, tbl[i].d, tbl[i].l, tbl[i].dat, tbl[i].ch, st);
            total_stalls += st;
            if (i == 0) begin
                chk("latency_out_valid", 64'(out_valid), 64'b0001);
                chk("latency_busy", 64'(busy), 64'd1);
            end
        end
        chk("throughput_stalls", 64'(total_stalls), 64'd0);

        // Backpressure on locked channel 2
        out_ready = 4'b1011;
        send(1'b0, 2'd2, 1'b0, 8'hD0, 2, st);
        mode = 1'b0; in_dest = 2'd0; in_last = 1'b1; in_data = 8'hD1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'b0100);
            chk("bp_out_data", 64'(out_data), 64'h00D0_0000);
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
        send(1'b0, 2'd0, 1'b1, 8'hD1, 2, st);

        // Gap inside a round-robin burst; later words ignore mode/in_dest while locked
        send(1'b1, 2'd0, 1'b0, 8'hE0, 0, st);
        send(1'b1, 2'd0, 1'b0, 8'hE1, 0, st);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("gap_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        send(1'b0, 2'd3, 1'b0, 8'hE2, 0, st);
        send(1'b0, 2'd3, 1'b0, 8'hE3, 0, st);
        send(1'b1, 2'd0, 1'b1, 8'hE4, 1, st);

        // Reset mid-burst with a held word
        send(1'b1, 2'd0, 1'b0, 8'hF0, 2, st);
        send(1'b1, 2'd0, 1'b0, 8'hF1, 2, st);
        out_ready = 4'h0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        out_ready = 4'hF;
        send(1'b1, 2'd0, 1'b1, 8'hF2, 0, st);

        // Invalid destination on the NCH=3 instance
        b_mode = 1'b0; b_in_dest = 2'd3; b_in_last = 1'b1; b_in_data = 8'h55; b_in_valid = 1'b1;
        @(negedge clk);
        chk("bad_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bad_drop", 64'(b_drop), 64'd1);
        chk("bad_out_valid", 64'(b_out_valid), 64'd0);
        chk("bad_busy", 64'(b_busy), 64'd0);
        b_in_dest = 2'd2; b_in_data = 8'h66;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("bad_drop_pulse", 64'(b_drop), 64'd0);
        chk("good_out_valid", 64'(b_out_valid), 64'b100);
        chk("good_out_data", 64'(b_out_data), 64'h66_0000);
        chk("good_cur_sel", 64'(b_cur_sel), 64'd2);

        // Drain scoreboard
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_stream_sched.md
Name: demux_stream_sched

Overview:
- Sequencing controller for the 1-to-N data demux: accepts one valid/ready input stream and steers each word to exactly one of NCH output channels.
- Two channel-selection modes:
  - directed: channel taken from a destination field;
  - round-robin: channel rotates after each burst.
- Bursts are locked to one channel until BURST words have been sent or in_last is seen.
- Sits between an upstream producer and NCH downstream consumers; replaces the bare combinational demux select with a registered, handshaked scheduler.

Parameters:
- DW, 8, data word width.
- NCH, 4, number of output channels (2..16; need not be a power of 2).
- SW, 2, select width; SW = ceil(log2(NCH)).
- BURST, 4, maximum words per burst before the channel lock releases (1..255).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  DW  input word.
- in_valid  input  1  in_data/in_dest/in_last valid.
- in_ready  output  1  block accepts the word this cycle.
- in_dest  input  SW  destination channel; directed mode only; sampled on first word of a burst.
- in_last  input  1  marks final word of a burst.
- mode  input  1  0 = directed, 1 = round-robin; sampled on first word of a burst.
- out_data  output  NCH*DW  lane k = bits [k*DW +: DW].
- out_valid  output  NCH  one-hot or zero.
- out_ready  input  NCH  per-channel consumer ready.
- cur_sel  output  SW  channel currently locked or being driven.
- busy  output  1  burst lock active or output register full.
- drop  output  1  one-cycle pulse when a word is discarded.

Behaviour:
- Accept = in_valid & in_ready. Transfer = out_valid[cur_sel] & out_ready[cur_sel].
- Reset (rst_n=0 at a clock edge):
  - Registers: state=IDLE, out_valid=0, out_data=0, cur_sel=0, busy=0, drop=0, rr_ptr=0, beat_cnt=0, locked=0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-burst discards the held word and the lock; no out_valid may remain asserted the cycle after reset.
- States:
  - IDLE: output register empty; in_ready=1.
  - SEND: output register full; in_ready = out_ready[cur_sel] (pass-through, zero bubble).
- Channel choice on an accepted word when locked=0:
  - mode=0: sel=in_dest.
  - mode=1: sel=rr_ptr.
  - Set locked=1, beat_cnt=1.
  - When locked=1: sel=cur_sel, beat_cnt increments; in_dest and mode are ignored.
- Burst end:
  - Occurs on the accepted word with in_last=1, or when beat_cnt reaches BURST.
  - At the end-of-burst accept, locked clears.
  - If the burst was a round-robin burst, rr_ptr advances to (cur_sel+1), wrapping NCH-1 -> 0.
  - Directed bursts do not move rr_ptr.
- Output stage:
  - An accepted word is registered; out_valid[sel] rises the next cycle, with lane sel = word and all other lanes = 0.
  - Latency: input accept to out_valid is 1 cycle.
  - Throughput: 1 word/cycle when out_ready is held high.
- Transitions:
  - IDLE -> SEND on accept.
  - SEND -> SEND on transfer with simultaneous accept (new word loaded, possibly to a new channel if the burst ended).
  - SEND -> IDLE on transfer without accept.
  - SEND holds while out_ready[cur_sel]=0: data stable, out_valid stable.
- Lock across gaps: locked and beat_cnt persist through IDLE, so the next word continues the same burst on the same channel.
- Invalid destination:
  - Applies in directed mode when in_dest >= NCH on a burst's first word.
  - The word is accepted, not forwarded; drop pulses 1 cycle; no lock is taken; state unchanged.
- Outputs:
  - out_valid is never multi-hot.
  - cur_sel tracks the channel of the held or locked word.
  - busy = locked | (state==SEND).

Test Plan:
- Reset mid-burst: mode=1, send 2 words, then assert rst_n=0 for 1 cycle -> next cycle out_valid=0, busy=0; the next word goes to channel 0.
- Round-robin, BURST=4, out_ready=all 1, 10 words, no in_last -> words 0-3 on ch0, 4-7 on ch1, 8-9 on ch2; 1 word/cycle; first out_valid 1 cycle after first accept.
- Directed with in_last: in_dest=3, 2 words (second with in_last), then in_dest=1, 1 word with in_last -> ch3 gets 2 words, ch1 gets 1; rr_ptr stays 0.
- Backpressure: ch2 locked, out_ready[2]=0 for 5 cycles -> in_ready=0, out_data lane 2 stable, out_valid=4'b0100 held; releasing out_ready resumes transfer with no loss or duplication.
- Gap in burst: round-robin, 2 words, in_valid low 3 cycles, 2 more words -> all 4 on ch0, busy=1 during the gap, rr_ptr=1 afterwards.
- Invalid dest, NCH=3: directed, in_dest=3 -> word accepted, drop=1 for one cycle, out_valid stays 0, next valid word routes normally.
